// File: rtl/cis_line_seq_pkg.sv
// Shared types for the CIS line-scan sequencer.
// Holds state encodings and the minimum line length helper.
package cis_line_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SP     = 3'd1,
    ST_DUMMY  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  function automatic int min_line(
    input int dummy_pix,
    input int active_pix
  );
    return 1 + dummy_pix + active_pix;
  endfunction

endpackage

// File: rtl/cis_line_seq_if.sv
// Control and timing bundle between sequencer,
// ADC config writer and pixel capture logic.
interface cis_line_seq_if;

  logic        cfg_done;
  logic        start_cis;
  logic [15:0] sp_para;
  logic        cis_sp;
  logic        adc_cds;
  logic        cis_wren;
  logic [11:0] pix_idx;
  logic        line_done;
  logic        busy;
  logic        err_short;

  modport master (
    input  cfg_done,
    input  start_cis,
    input  sp_para,
    output cis_sp,
    output adc_cds,
    output cis_wren,
    output pix_idx,
    output line_done,
    output busy,
    output err_short
  );

  modport slave (
    output cfg_done,
    output start_cis,
    output sp_para,
    input  cis_sp,
    input  adc_cds,
    input  cis_wren,
    input  pix_idx,
    input  line_done,
    input  busy,
    input  err_short
  );

endinterface

// File: rtl/cis_line_seq_pix_tick_gen.sv
// Pixel-period divider: counts adc_clk cycles within a pixel.
// Exposes its next value so the top can register decoded outputs.
module pix_tick_gen #(
  parameter int PIX_DIV = 4,
  parameter int DW      = $clog2(PIX_DIV)
) (
  input  logic          adc_clk,
  input  logic          reset_n,
  input  logic          clear,
  output logic [DW-1:0] div,
  output logic [DW-1:0] div_nxt,
  output logic          pix_last
);

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  always_comb begin
    pix_last = (div == DIV_LAST);
    div_nxt  = div + 1'b1;
    if (clear || pix_last) begin
      div_nxt = '0;
    end
  end

  always_ff @(negedge adc_clk) begin
    if (!reset_n) begin
      div <= '0;
    end else begin
      div <= div_nxt;
    end
  end

endmodule

// File: rtl/cis_line_seq.sv
// CIS line-scan sequencer: SP pulse, CDS gating, pixel strobes.
// All state and outputs update on the falling edge of adc_clk.
module cis_line_seq
  import cis_line_seq_pkg::*;
#(
  parameter int PIX_DIV    = 4,
  parameter int SP_WIDTH   = 2,
  parameter int DUMMY_PIX  = 2,
  parameter int ACTIVE_PIX = 4
) (
  input  logic           adc_clk,
  input  logic           reset_n,
  cis_line_seq_if.master bus
);

  localparam int DW = $clog2(PIX_DIV);
  localparam logic [15:0] MIN_L =
    16'(min_line(DUMMY_PIX, ACTIVE_PIX));
  localparam logic [15:0] FIRST_ACT = 16'(1 + DUMMY_PIX);
  localparam logic [15:0] LAST_ACT  = 16'(DUMMY_PIX + ACTIVE_PIX);
  localparam logic [15:0] DUMMY_END = 16'(DUMMY_PIX);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  state_t        state, state_n;
  logic [15:0]   pcnt, pcnt_n;
  logic [15:0]   len_q;
  logic [15:0]   len_req;
  logic          line_start;
  logic          go;
  logic          short_req;
  logic          tick_clear;
  logic [DW-1:0] div, div_nxt;
  logic          pix_last;

  logic          cis_sp_q, adc_cds_q, cis_wren_q;
  logic          line_done_q, busy_q, err_q;
  logic [11:0]   pix_idx_q;

  pix_tick_gen #(
    .PIX_DIV (PIX_DIV),
    .DW      (DW)
  ) u_tick (
    .adc_clk  (adc_clk),
    .reset_n  (reset_n),
    .clear    (tick_clear),
    .div      (div),
    .div_nxt  (div_nxt),
    .pix_last (pix_last)
  );

  assign go        = bus.start_cis & bus.cfg_done;
  assign short_req = (bus.sp_para < MIN_L);
  assign len_req   = short_req ? MIN_L : bus.sp_para;

  always_comb begin
    state_n    = state;
    pcnt_n     = pcnt;
    line_start = 1'b0;
    if (state == ST_IDLE) begin
      if (go) begin
        state_n    = ST_SP;
        pcnt_n     = '0;
        line_start = 1'b1;
      end
    end else if (!bus.cfg_done) begin
      state_n = ST_IDLE;
      pcnt_n  = '0;
    end else if (pix_last) begin
      if (pcnt == len_q - 16'd1) begin
        pcnt_n = '0;
        if (go) begin
          state_n    = ST_SP;
          line_start = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end else begin
        pcnt_n = pcnt + 16'd1;
        unique case (1'b1)
          (pcnt_n <= DUMMY_END): state_n = ST_DUMMY;
          (pcnt_n >  DUMMY_END && pcnt_n <= LAST_ACT):
            state_n = ST_ACTIVE;
          (pcnt_n >  LAST_ACT):  state_n = ST_GAP;
        endcase
      end
    end
  end

  assign tick_clear = line_start || (state_n == ST_IDLE);

  // Outputs are decoded from next-state values so they line up with state.
  always_ff @(negedge adc_clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pcnt        <= '0;
      len_q       <= MIN_L;
      err_q       <= 1'b0;
      cis_sp_q    <= 1'b0;
      adc_cds_q   <= 1'b0;
      cis_wren_q  <= 1'b0;
      pix_idx_q   <= '0;
      line_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      if (line_start) begin
        len_q <= len_req;
      end
      if (state_n == ST_IDLE && !bus.start_cis) begin
        err_q <= 1'b0;
      end else if (line_start && short_req) begin
        err_q <= 1'b1;
      end
      cis_sp_q   <= (state_n == ST_SP) &&
                    (int'(div_nxt) < SP_WIDTH);
      adc_cds_q  <= (state_n != ST_IDLE) &&
                    (int'(div_nxt) < PIX_DIV / 2);
      cis_wren_q <= (state_n == ST_ACTIVE) &&
                    (div_nxt == DIV_LAST);
      pix_idx_q  <= (state_n == ST_ACTIVE) ?
                    12'(pcnt_n - FIRST_ACT) : 12'd0;
      line_done_q <= (state_n == ST_ACTIVE) &&
                     (div_nxt == DIV_LAST) &&
                     (pcnt_n == LAST_ACT);
      busy_q     <= (state_n != ST_IDLE);
    end
  end

  assign bus.cis_sp    = cis_sp_q;
  assign bus.adc_cds   = adc_cds_q;
  assign bus.cis_wren  = cis_wren_q;
  assign bus.pix_idx   = pix_idx_q;
  assign bus.line_done = line_done_q;
  assign bus.busy      = busy_q;
  assign bus.err_short = err_q;

endmodule

// File: tb/tb_cis_line_seq.sv
// Self-checking bench for cis_line_seq: directed steps plus
// random traffic against a line-cycle-count reference model.
module tb_cis_line_seq;

  localparam int PD   = 4;
  localparam int SPW  = 2;
  localparam int DP   = 2;
  localparam int AP   = 4;
  localparam int MINL = 1 + DP + AP;

  logic adc_clk = 1'b1;
  logic reset_n;

  cis_line_seq_if bus ();

  cis_line_seq #(
    .PIX_DIV    (PD),
    .SP_WIDTH   (SPW),
    .DUMMY_PIX  (DP),
    .ACTIVE_PIX (AP)
  ) dut (
    .adc_clk (adc_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 adc_clk = ~adc_clk;

  int checks   = 0;
  int failures = 0;

  // Model: running flag, cycle within line, line length, error flag.
  bit m_act;
  int m_lc;
  int m_len;
  bit m_err;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_line();
    int sp;
    sp     = int'(bus.sp_para);
    m_act  = 1'b1;
    m_lc   = 0;
    m_len  = (sp < MINL) ? MINL : sp;
    if (sp < MINL) m_err = 1'b1;
  endtask

  task automatic model_edge();
    bit go;
    go = bus.cfg_done && bus.start_cis;
    if (!reset_n) begin
      m_act = 1'b0;
      m_lc  = 0;
      m_len = MINL;
      m_err = 1'b0;
    end else begin
      if (!m_act) begin
        if (go) start_line();
      end else if (!bus.cfg_done) begin
        m_act = 1'b0;
        m_lc  = 0;
      end else if (m_lc == m_len * PD - 1) begin
        if (go) start_line();
        else begin
          m_act = 1'b0;
          m_lc  = 0;
        end
      end else begin
        m_lc++;
      end
      if (!m_act && !bus.start_cis) m_err = 1'b0;
    end
  endtask

  task automatic check_all();
    int p, d;
    bit in_act, wr;
    p      = m_lc / PD;
    d      = m_lc % PD;
    in_act = m_act && p >= 1 + DP && p < 1 + DP + AP;
    wr     = in_act && d == PD - 1;
    chk("busy", 16'(bus.busy), 16'(m_act));
    chk("cis_sp", 16'(bus.cis_sp),
        16'(m_act && p == 0 && d < SPW));
    chk("adc_cds", 16'(bus.adc_cds), 16'(m_act && d < PD / 2));
    chk("cis_wren", 16'(bus.cis_wren), 16'(wr));
    chk("pix_idx", 16'(bus.pix_idx),
        in_act ? 16'(p - 1 - DP) : 16'd0);
    chk("line_done", 16'(bus.line_done),
        16'(wr && p == DP + AP));
    chk("err_short", 16'(bus.err_short), 16'(m_err));
  endtask

  task automatic step();
    @(negedge adc_clk);
    model_edge();
    @(posedge adc_clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    bit exp_w;
    reset_n       = 1'b0;
    bus.cfg_done  = 1'b0;
    bus.start_cis = 0;
    bus.sp_para   = 16'd0;
    m_act = 0; m_lc = 0; m_len = MINL; m_err = 0;
    run(2);
    reset_n = 1'b1;
    run(2);

    // Line of 10 pixels; cycle k = k-th sample after the start edge.
    bus.cfg_done  = 1'b1;
    bus.start_cis = 1'b1;
    bus.sp_para   = 16'd10;
    for (int k = 0; k < 42; k++) begin
      step();
      exp_w = (k == 15 || k == 19 || k == 23 || k == 27);
      chk("s1_wren_dir", 16'(bus.cis_wren), 16'(exp_w));
      if (k == 27) chk("s1_done27", 16'(bus.line_done), 16'd1);
      if (k == 25) chk("s1_idx", 16'(bus.pix_idx), 16'd3);
      if (k == 40) chk("s1_sp40", 16'(bus.cis_sp), 16'd1);
      if (k == 1)  chk("s1_sp1", 16'(bus.cis_sp), 16'd1);
      if (k == 2)  chk("s1_sp2", 16'(bus.cis_sp), 16'd0);
    end

    // Short request clamps to the minimum line and flags it.
    bus.sp_para = 16'd5;
    run(90);
    chk("s2_err", 16'(bus.err_short), 16'd1);

    // Scan enable dropped mid-line: line finishes, then idle.
    bus.sp_para = 16'd10;
    run(30);
    bus.start_cis = 1'b0;
    run(60);
    chk("s3_idle", 16'(bus.busy), 16'd0);

    // Config lost mid-line: immediate abort.
    bus.start_cis = 1'b1;
    run(18);
    bus.cfg_done = 1'b0;
    step();
    chk("s4_abort", 16'(bus.busy), 16'd0);
    run(5);
    bus.cfg_done = 1'b1;

    // Length change mid-line, then reset mid-line.
    run(10);
    bus.sp_para = 16'd12;
    run(75);
    reset_n = 1'b0;
    step();
    chk("s5_rst", 16'(bus.busy), 16'd0);
    reset_n = 1'b1;
    bus.start_cis = 1'b0;
    run(3);

    // Enable without config never starts a line.
    bus.cfg_done  = 1'b0;
    bus.start_cis = 1'b1;
    run(100);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset_n       = ($urandom_range(0, 199) != 0);
      bus.cfg_done  = ($urandom_range(0, 99) > 2);
      bus.start_cis = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0)
        bus.sp_para = 16'($urandom_range(0, 14));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
